// File: rtl/isqrt_seq_if.sv
// isqrt_seq_if -- handshake bundle for the sequential integer square root.
//   in_valid  : radicand x is valid              (master -> slave)
//   in_ready  : block can accept x               (slave  -> master)
//   x         : unsigned radicand, WIDTH bits    (master -> slave)
//   out_valid : root/rem valid, held until taken (slave  -> master)
//   out_ready : downstream accepts the result    (master -> slave)
//   root      : square root, WIDTH/2 bits        (slave  -> master)
//   rem       : x - floor(sqrt(x))^2, WIDTH/2+1  (slave  -> master)
interface isqrt_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     x;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH/2-1:0]   root;
    logic [WIDTH/2:0]     rem;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, root, rem
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, root, rem
    );
endinterface

// File: rtl/isqrt_seq.sv
// isqrt_seq -- sequential restoring integer square root.
//   Returns root = floor(sqrt(x)) and rem = x - root^2, one root bit per
//   clock through a single trial subtractor. Accept at edge k, result valid
//   after edge k+WIDTH/2; result held until out_ready.
// Parameters:
//   WIDTH : radicand width (even, >= 4); root is WIDTH/2 bits.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst   : synchronous reset, active-high; aborts any calculation
//   bus   : isqrt_seq_if.slave (in_valid/in_ready/x, out_valid/out_ready/root/rem)
// Build option:
//   ISQRT_ROUND_EN : when defined, root is rounded to nearest (saturating at
//                    all-ones); rem still reports the floor remainder.
module isqrt_seq #(
    parameter int unsigned WIDTH = 16
) (
    input logic        clk,
    input logic        rst,
    isqrt_seq_if.slave bus
);
    localparam int unsigned HW = WIDTH / 2;
    localparam int unsigned CW = (HW > 2) ? $clog2(HW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] xs;      // radicand shift register
    logic [HW+1:0]    r_q;     // partial remainder R
    logic [HW-1:0]    q_q;     // partial root Q
    logic [CW-1:0]    cnt;     // iterations remaining after the current one
    logic [HW-1:0]    root_q;
    logic [HW:0]      rem_q;

    logic [HW+1:0]    r_sh;
    logic [HW+1:0]    t_val;
    logic             ge;
    logic [HW+1:0]    r_nxt;
    logic [HW-1:0]    q_nxt;
    logic [HW-1:0]    root_fin;

    // One restoring iteration. R stays below 2^HW before the shift, so
    // truncating the concatenation drops only zero bits.
    always_comb begin
        r_sh  = (HW+2)'({r_q, xs[WIDTH-1 -: 2]});
        t_val = {q_q, 2'b01};
        ge    = (r_sh >= t_val);
        r_nxt = ge ? (r_sh - t_val) : r_sh;
        q_nxt = {q_q[HW-2:0], ge};
    end

`ifdef ISQRT_ROUND_EN
    // Round up when x - Q^2 > Q, i.e. x > (Q + 1/2)^2; hold at all-ones.
    always_comb begin
        root_fin = q_nxt;
        if ((r_nxt > {2'b00, q_nxt}) && !(&q_nxt))
            root_fin = q_nxt + HW'(1);
    end
`else
    always_comb begin
        root_fin = q_nxt;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid)  state_nxt = CALC;
            CALC: if (cnt == '0)     state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.root      = root_q;
        bus.rem       = rem_q;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            xs     <= '0;
            r_q    <= '0;
            q_q    <= '0;
            cnt    <= '0;
            root_q <= '0;
            rem_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        xs  <= bus.x;
                        r_q <= '0;
                        q_q <= '0;
                        cnt <= CW'(HW - 1);
                    end
                end
                CALC: begin
                    xs  <= {xs[WIDTH-3:0], 2'b00};
                    r_q <= r_nxt;
                    q_q <= q_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        root_q <= root_fin;
                        rem_q  <= r_nxt[HW:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
